// File: rtl/mem_access_stage.sv
// Load/store stage in front of the data memory: one request in flight,
// drives memory strobes, returns a registered result to writeback.
// Ports: clk, reset_n; req_* handshake from execute; mem_* to the data
// memory; wb_* handshake and result fields to the writeback stage.
module mem_access_stage #(
   parameter int MEM_DEPTH   = 8,
   parameter int WAIT_CYCLES = 1,
   parameter int REG_W       = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_is_store,
   input  logic [15:0]      req_addr,
   input  logic [15:0]      req_wdata,
   input  logic [REG_W-1:0] req_rd,
   output logic [15:0]      mem_access_addr,
   output logic [15:0]      mem_write_data,
   output logic             mem_write_en,
   output logic             mem_read,
   input  logic [15:0]      mem_read_data,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [15:0]      wb_data,
   output logic [REG_W-1:0] wb_rd,
   output logic             wb_we,
   output logic             wb_err
);

   typedef enum logic [1:0] {
      IDLE,
      STORE,
      LOAD,
      RESP
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [15:0]      addr_q;
   logic [15:0]      wdata_q;
   logic [REG_W-1:0] rd_q;
   logic [3:0]       cnt;
   logic             in_range;
   logic             accept;

   // Full-width compare: high address bits must never alias a legal word.
   assign in_range = {1'b0, req_addr} < 17'(MEM_DEPTH);
   assign accept   = (state == IDLE) && req_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (!in_range) begin
                  state_nxt = RESP;
               end else if (req_is_store) begin
                  state_nxt = STORE;
               end else begin
                  state_nxt = LOAD;
               end
            end
         end
         STORE: state_nxt = RESP;
         LOAD: begin
            if (cnt == 4'd0) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (wb_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
         cnt     <= '0;
         wb_data <= '0;
         wb_we   <= 1'b0;
         wb_err  <= 1'b0;
      end else if (accept) begin
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         rd_q    <= req_rd;
         cnt     <= 4'(WAIT_CYCLES);
         wb_data <= '0;
         wb_we   <= 1'b0;
         wb_err  <= !in_range;
      end else if (state == LOAD) begin
         if (cnt == 4'd0) begin
            wb_data <= mem_read_data;
            wb_we   <= 1'b1;
         end else begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   // Strobes decode straight from the state register so reset kills
   // them without waiting for a clock edge.
   assign req_ready       = (state == IDLE);
   assign mem_write_en    = (state == STORE);
   assign mem_read        = (state == LOAD);
   assign wb_valid        = (state == RESP);
   assign mem_access_addr = addr_q;
   assign mem_write_data  = wdata_q;
   assign wb_rd           = rd_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: one instance with WAIT_CYCLES=2,
// one with WAIT_CYCLES=0 for back-to-back traffic; each has a memory model.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   // Instance A: WAIT_CYCLES = 2
   logic        req_valid, req_ready, req_is_store;
   logic [15:0] req_addr, req_wdata;
   logic [2:0]  req_rd;
   logic [15:0] mem_access_addr, mem_write_data, mem_read_data;
   logic        mem_write_en, mem_read;
   logic        wb_valid, wb_ready, wb_we, wb_err;
   logic [15:0] wb_data;
   logic [2:0]  wb_rd;

   // Instance B: WAIT_CYCLES = 0
   logic        b_req_valid, b_req_ready, b_req_is_store;
   logic [15:0] b_req_addr, b_req_wdata;
   logic [2:0]  b_req_rd;
   logic [15:0] b_mem_access_addr, b_mem_write_data, b_mem_read_data;
   logic        b_mem_write_en, b_mem_read;
   logic        b_wb_valid, b_wb_ready, b_wb_we, b_wb_err;
   logic [15:0] b_wb_data;
   logic [2:0]  b_wb_rd;

   logic [15:0] mem [8] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003,
                            16'hA004, 16'h0002, 16'hA006, 16'hA007};
   logic [15:0] b_mem [8] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003,
                              16'hA004, 16'hA005, 16'hA006, 16'hA007};

   assign mem_read_data = (mem_access_addr < 16'd8)
                        ? mem[mem_access_addr[2:0]] : 16'h0;
   assign b_mem_read_data = (b_mem_access_addr < 16'd8)
                          ? b_mem[b_mem_access_addr[2:0]] : 16'h0;

   always @(posedge clk) begin
      if (mem_write_en && mem_access_addr < 16'd8)
         mem[mem_access_addr[2:0]] <= mem_write_data;
      if (b_mem_write_en && b_mem_access_addr < 16'd8)
         b_mem[b_mem_access_addr[2:0]] <= b_mem_write_data;
   end

   mem_access_stage #(.MEM_DEPTH(8), .WAIT_CYCLES(2), .REG_W(3)) u_a (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_is_store(req_is_store), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_rd(req_rd),
      .mem_access_addr(mem_access_addr),
      .mem_write_data(mem_write_data),
      .mem_write_en(mem_write_en), .mem_read(mem_read),
      .mem_read_data(mem_read_data),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
      .wb_rd(wb_rd), .wb_we(wb_we), .wb_err(wb_err)
   );

   mem_access_stage #(.MEM_DEPTH(8), .WAIT_CYCLES(0), .REG_W(3)) u_b (
      .clk(clk), .reset_n(reset_n),
      .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_is_store(b_req_is_store), .req_addr(b_req_addr),
      .req_wdata(b_req_wdata), .req_rd(b_req_rd),
      .mem_access_addr(b_mem_access_addr),
      .mem_write_data(b_mem_write_data),
      .mem_write_en(b_mem_write_en), .mem_read(b_mem_read),
      .mem_read_data(b_mem_read_data),
      .wb_valid(b_wb_valid), .wb_ready(b_wb_ready), .wb_data(b_wb_data),
      .wb_rd(b_wb_rd), .wb_we(b_wb_we), .wb_err(b_wb_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic st, input logic [15:0] a,
                        input logic [15:0] d, input logic [2:0] rd);
      req_valid    = 1'b1;
      req_is_store = st;
      req_addr     = a;
      req_wdata    = d;
      req_rd       = rd;
   endtask

   initial begin
      reset_n = 1'b0;
      req_valid = 0; req_is_store = 0; req_addr = 0;
      req_wdata = 0; req_rd = 0; wb_ready = 0;
      b_req_valid = 0; b_req_is_store = 0; b_req_addr = 0;
      b_req_wdata = 0; b_req_rd = 0; b_wb_ready = 0;
      #3;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_write_en", mem_write_en, 0);
      chk("rst_mem_read", mem_read, 0);
      chk("rst_addr", mem_access_addr, 0);
      chk("rst_wdata", mem_write_data, 0);
      chk("rst_wb_data", wb_data, 0);
      tick; tick;
      reset_n = 1'b1;
      tick;

      // Store addr 3 <- 0x1234
      drive(1'b1, 16'd3, 16'h1234, 3'd1);
      tick;
      req_valid = 0;
      chk("st_we_t1", mem_write_en, 1);
      chk("st_addr_t1", mem_access_addr, 3);
      chk("st_data_t1", mem_write_data, 16'h1234);
      chk("st_valid_t1", wb_valid, 0);
      chk("st_ready_t1", req_ready, 0);
      tick;
      chk("st_we_t2", mem_write_en, 0);
      chk("st_valid_t2", wb_valid, 1);
      chk("st_wbwe_t2", wb_we, 0);
      chk("st_err_t2", wb_err, 0);
      chk("st_data_t2", wb_data, 0);
      wb_ready = 1;
      tick;
      wb_ready = 0;
      chk("st_valid_done", wb_valid, 0);
      chk("st_ready_done", req_ready, 1);
      chk("st_mem3", mem[3], 16'h1234);

      // Load addr 5 (holds 0x0002), rd 6, WAIT_CYCLES 2
      drive(1'b0, 16'd5, 16'h0, 3'd6);
      tick;
      req_valid = 0;
      for (int i = 0; i < 3; i++) begin
         chk("ld_read_win", mem_read, 1);
         chk("ld_valid_early", wb_valid, 0);
         tick;
      end
      chk("ld_read_end", mem_read, 0);
      chk("ld_valid", wb_valid, 1);
      chk("ld_data", wb_data, 16'h0002);
      chk("ld_rd", wb_rd, 6);
      chk("ld_we", wb_we, 1);
      chk("ld_err", wb_err, 0);
      // Stall for 5 more cycles with a stray request in the middle
      for (int i = 0; i < 5; i++) begin
         if (i == 2) drive(1'b1, 16'd0, 16'hFFFF, 3'd0);
         tick;
         req_valid = 0;
         chk("stall_valid", wb_valid, 1);
         chk("stall_data", wb_data, 16'h0002);
         chk("stall_ready", req_ready, 0);
         chk("stall_we", mem_write_en, 0);
      end
      wb_ready = 1;
      tick;
      wb_ready = 0;
      chk("stall_release_valid", wb_valid, 0);
      chk("stall_release_ready", req_ready, 1);
      chk("stall_mem0", mem[0], 16'hA000);

      // Out-of-range load at MEM_DEPTH
      drive(1'b0, 16'd8, 16'h0, 3'd2);
      tick;
      req_valid = 0;
      chk("err_valid", wb_valid, 1);
      chk("err_err", wb_err, 1);
      chk("err_we", wb_we, 0);
      chk("err_data", wb_data, 0);
      chk("err_read", mem_read, 0);
      chk("err_write", mem_write_en, 0);
      chk("err_addr", mem_access_addr, 8);
      wb_ready = 1;
      tick;
      wb_ready = 0;
      chk("err_done", wb_valid, 0);

      // Store whose low bits alias word 0 must be rejected
      drive(1'b1, 16'h0108, 16'h1111, 3'd0);
      tick;
      req_valid = 0;
      chk("alias_write", mem_write_en, 0);
      chk("alias_err", wb_err, 1);
      chk("alias_valid", wb_valid, 1);
      wb_ready = 1;
      tick;
      wb_ready = 0;
      chk("alias_mem0", mem[0], 16'hA000);

      // Last legal address
      drive(1'b0, 16'd7, 16'h0, 3'd7);
      tick;
      req_valid = 0;
      tick; tick; tick;
      chk("ld7_valid", wb_valid, 1);
      chk("ld7_data", wb_data, 16'hA007);
      chk("ld7_err", wb_err, 0);
      chk("ld7_we", wb_we, 1);
      chk("ld7_rd", wb_rd, 7);
      wb_ready = 1;
      tick;
      wb_ready = 0;

      // Reset in the middle of a store
      drive(1'b1, 16'd2, 16'h5555, 3'd0);
      tick;
      req_valid = 0;
      chk("rs_we_before", mem_write_en, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("rs_we_async", mem_write_en, 0);
      chk("rs_ready_async", req_ready, 1);
      chk("rs_addr_async", mem_access_addr, 0);
      chk("rs_wdata_async", mem_write_data, 0);
      tick;
      reset_n = 1'b1;
      tick;
      chk("rs_ready_after", req_ready, 1);
      chk("rs_valid_after", wb_valid, 0);
      chk("rs_we_after", mem_write_en, 0);
      chk("rs_mem2", mem[2], 16'hA002);

      // Reset in the middle of a load
      drive(1'b0, 16'd1, 16'h0, 3'd3);
      tick;
      req_valid = 0;
      tick;
      chk("rl_read_before", mem_read, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("rl_read_async", mem_read, 0);
      chk("rl_addr_async", mem_access_addr, 0);
      tick;
      reset_n = 1'b1;
      tick;
      chk("rl_valid_after", wb_valid, 0);
      chk("rl_wbwe_after", wb_we, 0);
      chk("rl_wbdata_after", wb_data, 0);
      chk("rl_wbrd_after", wb_rd, 0);
      chk("rl_ready_after", req_ready, 1);
      chk("rl_read_after", mem_read, 0);

      // Instance B: store then load to the same word, back to back
      b_wb_ready = 1;
      b_req_valid = 1; b_req_is_store = 1;
      b_req_addr = 16'd4; b_req_wdata = 16'hBEEF; b_req_rd = 3'd0;
      tick;
      b_req_is_store = 0; b_req_wdata = 16'h0; b_req_rd = 3'd5;
      chk("bb_we", b_mem_write_en, 1);
      chk("bb_ready_busy", b_req_ready, 0);
      tick;
      chk("bb_st_valid", b_wb_valid, 1);
      chk("bb_st_wbwe", b_wb_we, 0);
      chk("bb_ready_resp", b_req_ready, 0);
      tick;
      chk("bb_ready_idle", b_req_ready, 1);
      chk("bb_valid_idle", b_wb_valid, 0);
      tick;
      b_req_valid = 0;
      chk("bb_read", b_mem_read, 1);
      chk("bb_read_addr", b_mem_access_addr, 4);
      tick;
      chk("bb_ld_valid", b_wb_valid, 1);
      chk("bb_ld_data", b_wb_data, 16'hBEEF);
      chk("bb_ld_rd", b_wb_rd, 5);
      chk("bb_ld_we", b_wb_we, 1);
      chk("bb_read_off", b_mem_read, 0);
      tick;
      chk("bb_done", b_wb_valid, 0);
      b_wb_ready = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
